// File: rtl/led_pkg.sv
// Shared types and constants for the breathing-LED sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } led_state_e;

    typedef logic [1:0] led_state_t;

    localparam led_state_t ST_RISE    = 2'd0;
    localparam led_state_t ST_HOLD_HI = 2'd1;
    localparam led_state_t ST_FALL    = 2'd2;
    localparam led_state_t ST_HOLD_LO = 2'd3;

    // Hold counter needs at least one bit even when HOLD_TICKS is 1.
    function automatic int hold_width(input int hold_ticks);
        return (hold_ticks > 1) ? $clog2(hold_ticks) : 1;
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// Free-running PWM counter with a registered duty comparator; usable for any dimmed output.
module pwm_compare #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] DUTY,
    output logic             LED
);

    logic [WIDTH-1:0] pcnt;

    // pcnt keeps running while EN is low so re-enabling stays phase-aligned.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pcnt <= '0;
            LED  <= 1'b0;
        end else begin
            pcnt <= pcnt + 1'b1;
            LED  <= EN & (DUTY > pcnt);
        end
    end

endmodule

// File: rtl/led_breathe_pwm.sv
// Breathing-LED sequencer (rise, hold, fall, hold) driving a PWM comparator.
// Define LED_BREATHE_GAMMA_EN for a squared (perceptual) duty curve with one extra cycle of latency.
module led_breathe_pwm
    import led_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HOLD_TICKS = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic             EN,
    output logic             LED,
    output logic [WIDTH-1:0] LEVEL,
    output logic [1:0]       STATE
);

    localparam int HW = hold_width(HOLD_TICKS);
    localparam logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}};
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);

    led_state_t       state;
    logic [WIDTH-1:0] level;
    logic [HW-1:0]    hcnt;
    logic [WIDTH-1:0] duty;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_RISE;
            level <= '0;
            hcnt  <= '0;
        end else if (TICK && EN) begin
            case (state)
                ST_RISE: begin
                    if (level != MAX) level <= level + 1'b1;
                    else begin
                        state <= ST_HOLD_HI;
                        hcnt  <= '0;
                    end
                end
                ST_HOLD_HI: begin
                    if (hcnt != HOLD_LAST) hcnt <= hcnt + 1'b1;
                    else begin
                        state <= ST_FALL;
                        hcnt  <= '0;
                    end
                end
                ST_FALL: begin
                    if (level != '0) level <= level - 1'b1;
                    else begin
                        state <= ST_HOLD_LO;
                        hcnt  <= '0;
                    end
                end
                ST_HOLD_LO: begin
                    if (hcnt != HOLD_LAST) hcnt <= hcnt + 1'b1;
                    else begin
                        state <= ST_RISE;
                        hcnt  <= '0;
                    end
                end
                default: begin
                    state <= ST_RISE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*WIDTH-1:0] sq;
    logic [2*WIDTH-1:0] sq_hi;

    assign sq    = {{WIDTH{1'b0}}, level} * {{WIDTH{1'b0}}, level};
    assign sq_hi = sq >> WIDTH;

    // Product is registered to keep the multiplier off the comparator path.
    always_ff @(posedge CLK) begin
        if (RESET) duty <= '0;
        else       duty <= sq_hi[WIDTH-1:0];
    end
`else
    assign duty = level;
`endif

    pwm_compare #(.WIDTH(WIDTH)) u_pwm (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .DUTY  (duty),
        .LED   (LED)
    );

    assign LEVEL = level;
    assign STATE = state;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Scoreboard bench for led_breathe_pwm: a tick-position reference model predicts LEVEL/STATE/LED each edge.
module tb_led_breathe_pwm;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int MAXV   = (1 << W) - 1;
    localparam int PERIOD = 2 * (1 << W) + 2 * H;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         TICK = 1'b0;
    logic         EN = 1'b1;
    logic         LED;
    logic [W-1:0] LEVEL;
    logic [1:0]   STATE;

    typedef struct {
        int level;
        int state;
        int led;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    led_breathe_pwm #(.WIDTH(W), .HOLD_TICKS(H)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (TICK),
        .EN    (EN),
        .LED   (LED),
        .LEVEL (LEVEL),
        .STATE (STATE)
    );

    always #5 CLK = ~CLK;

    // Brightness and phase as a function of accepted ticks within one breathing period.
    function automatic int lvl_of(input int pos);
        if (pos <= MAXV)                return pos;
        if (pos < MAXV + 1 + H)         return MAXV;
        if (pos < 2 * (MAXV + 1) + H)   return MAXV - (pos - (MAXV + 1 + H));
        return 0;
    endfunction

    function automatic int st_of(input int pos);
        if (pos <= MAXV)                return 0;
        if (pos < MAXV + 1 + H)         return 1;
        if (pos < 2 * (MAXV + 1) + H)   return 2;
        return 3;
    endfunction

    int n_m = 0, pc_m = 0, led_m = 0, duty_m = 0;

    always @(posedge CLK) begin
        exp_t e;
        int   cur, duty_now;
        if (RESET) begin
            n_m = 0; pc_m = 0; led_m = 0; duty_m = 0;
        end else begin
            cur = lvl_of(n_m);
`ifdef LED_BREATHE_GAMMA_EN
            duty_now = duty_m;
            duty_m   = (cur * cur) >> W;
`else
            duty_now = cur;
`endif
            led_m = (EN && (duty_now > pc_m)) ? 1 : 0;
            pc_m  = (pc_m + 1) % (1 << W);
            if (TICK && EN) n_m = (n_m + 1) % PERIOD;
        end
        e.level = lvl_of(n_m);
        e.state = st_of(n_m);
        e.led   = led_m;
        q.push_back(e);
    end

    always @(posedge CLK) begin
        exp_t e;
        #1;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got no expectation at %0t, required one", $time);
        end else begin
            e = q.pop_front();
            if (int'(LEVEL) !== e.level) begin
                fails++;
                $display("FAIL level @%0t: got %0d, required %0d", $time, LEVEL, e.level);
            end
            tests++;
            if (int'(STATE) !== e.state) begin
                fails++;
                $display("FAIL state @%0t: got %0d, required %0d", $time, STATE, e.state);
            end
            tests++;
            if ((LED === 1'b1 ? 1 : (LED === 1'b0 ? 0 : -1)) != e.led) begin
                fails++;
                $display("FAIL led @%0t: got %b, required %0d", $time, LED, e.led);
            end
        end
    end

    task automatic cyc(input logic t, input logic e, input logic r);
        @(negedge CLK);
        TICK = t; EN = e; RESET = r;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    // Counts LED highs over one full PWM window after the duty has settled.
    task automatic check_window(input string name, input int want);
        int ones = 0;
        idle(3);
        for (int i = 0; i < (1 << W); i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (LED === 1'b1) ones++;
        end
        tests++;
        if (ones != want) begin
            fails++;
            $display("FAIL %s: LED high %0d of %0d cycles, required %0d", name, ones, 1 << W, want);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic int gam(input int l);
`ifdef LED_BREATHE_GAMMA_EN
        return (l * l) >> W;
`else
        return l;
`endif
    endfunction

    initial begin
        do_reset();
        check_window("idle_off", 0);
        idle(13);

        // TICK held high: counts once per cycle.
        ticks(15);
        idle(1);
        check_val("rise_to_max_level", int'(LEVEL), MAXV);
        check_val("rise_to_max_state", int'(STATE), 0);
        check_window("duty_max", gam(MAXV));
        ticks(1);
        idle(1);
        check_val("hold_hi_entry", int'(STATE), 1);

        do_reset();
        ticks(5);
        check_window("duty_5", gam(5));
        ticks(3);
        check_window("duty_8", gam(8));
        ticks(PERIOD - 8);
        idle(1);
        check_val("full_period_level", int'(LEVEL), 0);
        check_val("full_period_state", int'(STATE), 0);

        // Freeze mid-FALL at level 9.
        do_reset();
        ticks(24);
        idle(1);
        check_val("mid_fall_level", int'(LEVEL), 9);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("frozen_level", int'(LEVEL), 9);
        check_val("frozen_led", int'(LED), 0);
        ticks(1);
        idle(1);
        check_val("resume_level", int'(LEVEL), 8);

        // Reset wins over a coincident tick in HOLD_HI.
        do_reset();
        ticks(17);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check_val("reset_tick_state", int'(STATE), 0);
        check_val("reset_tick_level", int'(LEVEL), 0);
        check_val("reset_tick_led", int'(LED), 0);

        for (int i = 0; i < 3000; i++) begin
            logic t, e, r;
            t = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 999) == 0);
            cyc(t, e, r);
        end

        idle(3);
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
